gcm_job_sequencer: RTL and testbench
====================================

// Module: gcm_job_sequencer
// PURPOSE
//  Sequences one AES-GCM job through the aes_gcm core: accepts a job descriptor, issues init,
//  streams AAD then text blocks from a 128-bit source, and inserts the len(A)||len(C) block.
//  Sits between the DMA/stream front end and the core; one job in flight at a time.
// PARAMETERS
//  LEN_W        16    width of block-count fields (max 2^LEN_W-1 blocks per section)
//  TIMEOUT_CYC  4096  cycles waiting on the core before a job is aborted
// PORTS
//  iClk              in   1    clock
//  iRstn             in   1    synchronous active-low reset
//  iJob_valid        in   1    job descriptor valid
//  oJob_ready        out  1    descriptor accepted when iJob_valid & oJob_ready
//  iJob_aad_blks     in   LEN_W  number of 128-bit AAD blocks (0 allowed)
//  iJob_txt_blks     in   LEN_W  number of 128-bit text blocks (0 allowed)
//  iJob_encdec       in   1    1=encrypt, 0=decrypt; latched at accept
//  iData             in   128  AAD blocks, then text blocks, in order
//  iData_valid       in   1    source beat valid
//  oData_ready       out  1    beat consumed when iData_valid & oData_ready
//  oCore_init        out  1    core iInit; high from accept until oDone/abort
//  oCore_encdec      out  1    latched iJob_encdec
//  iCore_ready       in   1    core oReady
//  oCore_aad         out  128  AAD block, or len block in LEN/WAIT_TAG
//  oCore_aad_valid   out  1    core iAad_valid
//  oCore_aad_last    out  1    core iAad_last
//  oCore_block       out  128  text block
//  oCore_block_valid out  1    core iBlock_valid
//  oCore_block_last  out  1    core iBlock_last
//  iCore_result_valid in  1    core oResult_valid (text block done)
//  iCore_tag_valid   in   1    core oTag_valid
//  oBusy             out  1    state != IDLE
//  oDone             out  1    one-cycle pulse: tag produced
//  oErr_timeout      out  1    sticky; cleared on next job accept
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0 except oJob_ready=1; counters, outstanding flag cleared.
//  Reset mid-job aborts immediately, no further core strobes.
//  States: IDLE -> KEY -> AAD -> TEXT -> LEN -> WAIT_TAG -> IDLE.
//  IDLE: oJob_ready=1; on accept latch counts/encdec, clear err, go KEY.
//  KEY: wait iCore_ready (hash key done), then AAD.
//  AAD: oData_ready = iCore_ready; each beat drives aad/aad_valid for 1 cycle; aad_last with
//   final beat; counter decrements. aad_blks=0: single-cycle aad_last pulse, aad_valid=0.
//  TEXT: one block outstanding max. oData_ready = iCore_ready & ~outstanding. Issue sets
//   outstanding; iCore_result_valid clears it. block_last with final beat. Leave to LEN when
//   last result returns. txt_blks=0: single-cycle block_last pulse with block_valid=0.
//  LEN: oCore_aad = {aad_blks*128 (64b), txt_blks*128 (64b)}, counts zero-extended, <<7.
//   Held stable through WAIT_TAG; no valid strobe (core samples it at tag).
//  WAIT_TAG: on iCore_tag_valid pulse oDone, drop oCore_init, return to IDLE.
//  Timeout: wait counter reloads on every core progress event (ready rise, result, tag);
//   reaching TIMEOUT_CYC in KEY/TEXT/WAIT_TAG sets oErr_timeout, drops init, goes IDLE.
//  Source stalls (iData_valid=0) never time out; core strobes only on accepted beats.
//  iJob_valid while busy ignored (oJob_ready=0).
// CONFIGURATION
//  GCM_SEQ_PERF_EN defined: adds out oPerf_cycles[31:0] = cycles from accept to oDone,
//   updated at oDone, reset 0, saturates at 2^32-1. Undefined: port and counter absent.
// TESTING
//  aad=1, txt=2, enc, NIST GCM-AES-128 TC4-style data -> 3 beats, one aad_last, block_last on
//   beat 3, len block 0x..0080_..0100, oDone once, core tag matches vector.
//  aad=0, txt=0 -> aad_last pulse, block_last pulse with valids low, len=0, oDone.
//  aad=2, txt=3, iData_valid toggling 1/0 -> no dropped/duplicated block, order preserved.
//  Core result held off 5000 cycles in TEXT -> oErr_timeout=1 at TIMEOUT_CYC, IDLE, ready=1.
//  iRstn low during TEXT -> next cycle all strobes 0, oBusy=0, oJob_ready=1.
//  Back-to-back jobs, second iJob_valid held during first -> accepted only after oDone.

Source files
------------

// File: rtl/gcm_job_sequencer.sv
// Job sequencer for an AES-GCM core: init, AAD beats, text beats, then the len(A)||len(C) block.
// Optional build macro GCM_SEQ_PERF_EN adds oPerf_cycles (accept-to-done cycle count).
module gcm_job_sequencer #(
  parameter int LEN_W       = 16,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic             iClk,
  input  logic             iRstn,
  input  logic             iJob_valid,
  output logic             oJob_ready,
  input  logic [LEN_W-1:0] iJob_aad_blks,
  input  logic [LEN_W-1:0] iJob_txt_blks,
  input  logic             iJob_encdec,
  input  logic [127:0]     iData,
  input  logic             iData_valid,
  output logic             oData_ready,
  output logic             oCore_init,
  output logic             oCore_encdec,
  input  logic             iCore_ready,
  output logic [127:0]     oCore_aad,
  output logic             oCore_aad_valid,
  output logic             oCore_aad_last,
  output logic [127:0]     oCore_block,
  output logic             oCore_block_valid,
  output logic             oCore_block_last,
  input  logic             iCore_result_valid,
  input  logic             iCore_tag_valid,
  output logic             oBusy,
  output logic             oDone,
  output logic             oErr_timeout
`ifdef GCM_SEQ_PERF_EN
  ,
  output logic [31:0]      oPerf_cycles
`endif
);

  localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYC - 1);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = {{(WAIT_W-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0]  CNT_ZERO  = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0]  CNT_ONE   = {{(LEN_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_KEY      = 3'd1,
    S_AAD      = 3'd2,
    S_TEXT     = 3'd3,
    S_LEN      = 3'd4,
    S_WAIT_TAG = 3'd5
  } state_t;

  state_t            state_r, state_nxt_s;
  logic [LEN_W-1:0]  aad_blks_r, aad_blks_nxt_s;
  logic [LEN_W-1:0]  txt_blks_r, txt_blks_nxt_s;
  logic [LEN_W-1:0]  remain_r, remain_nxt_s;
  logic              outstanding_r, outstanding_nxt_s;
  logic              key_armed_r, key_armed_nxt_s;
  logic              init_r, init_nxt_s;
  logic              encdec_r, encdec_nxt_s;
  logic              done_r, done_nxt_s;
  logic              err_r, err_nxt_s;
  logic              core_ready_d_r;
  logic [WAIT_W-1:0] wait_cnt_r;
  logic              wait_core_s, progress_s, timeout_s;
  logic              data_ready_s, aad_valid_s, aad_last_s, blk_valid_s, blk_last_s;
  logic [127:0]      len_blk_s;

  assign len_blk_s  = {64'({aad_blks_r, 7'b0000000}), 64'({txt_blks_r, 7'b0000000})};
  assign progress_s = (iCore_ready & ~core_ready_d_r) | iCore_result_valid | iCore_tag_valid;
  assign timeout_s  = wait_core_s & ~progress_s & (wait_cnt_r == WAIT_LAST);

  // Cycles in which the job is blocked on the core (a stalled source never counts).
  always_comb begin
    wait_core_s = 1'b0;
    case (state_r)
      S_KEY:      wait_core_s = 1'b1;
      S_TEXT:     wait_core_s = outstanding_r | (~iCore_ready & (iData_valid | (remain_r == CNT_ZERO)));
      S_WAIT_TAG: wait_core_s = 1'b1;
      default:    wait_core_s = 1'b0;
    endcase
  end

  // Next-state and core-strobe decode.
  always_comb begin
    state_nxt_s       = state_r;
    aad_blks_nxt_s    = aad_blks_r;
    txt_blks_nxt_s    = txt_blks_r;
    remain_nxt_s      = remain_r;
    outstanding_nxt_s = outstanding_r;
    key_armed_nxt_s   = key_armed_r;
    init_nxt_s        = init_r;
    encdec_nxt_s      = encdec_r;
    done_nxt_s        = 1'b0;
    err_nxt_s         = err_r;
    data_ready_s      = 1'b0;
    aad_valid_s       = 1'b0;
    aad_last_s        = 1'b0;
    blk_valid_s       = 1'b0;
    blk_last_s        = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (iJob_valid) begin
          state_nxt_s       = S_KEY;
          aad_blks_nxt_s    = iJob_aad_blks;
          txt_blks_nxt_s    = iJob_txt_blks;
          remain_nxt_s      = iJob_aad_blks;
          encdec_nxt_s      = iJob_encdec;
          init_nxt_s        = 1'b1;
          err_nxt_s         = 1'b0;
          outstanding_nxt_s = 1'b0;
          key_armed_nxt_s   = 1'b0;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_KEY: begin
        // The first KEY cycle still shows the core's pre-init ready level, so it is skipped.
        if (timeout_s) begin
          state_nxt_s = S_IDLE;
          init_nxt_s  = 1'b0;
          err_nxt_s   = 1'b1;
        end else if (iCore_ready && key_armed_r) begin
          state_nxt_s = S_AAD;
        end else begin
          key_armed_nxt_s = 1'b1;
        end
      end
      S_AAD: begin
        data_ready_s = iCore_ready & (remain_r != CNT_ZERO);
        if (remain_r == CNT_ZERO) begin
          if (iCore_ready) begin
            aad_last_s   = 1'b1;
            state_nxt_s  = S_TEXT;
            remain_nxt_s = txt_blks_r;
          end else begin
            aad_last_s = 1'b0;
          end
        end else if (iData_valid && data_ready_s) begin
          aad_valid_s  = 1'b1;
          aad_last_s   = (remain_r == CNT_ONE);
          remain_nxt_s = remain_r - CNT_ONE;
          if (remain_r == CNT_ONE) begin
            state_nxt_s  = S_TEXT;
            remain_nxt_s = txt_blks_r;
          end else begin
            state_nxt_s = S_AAD;
          end
        end else begin
          aad_valid_s = 1'b0;
        end
      end
      S_TEXT: begin
        if (timeout_s) begin
          state_nxt_s       = S_IDLE;
          init_nxt_s        = 1'b0;
          err_nxt_s         = 1'b1;
          outstanding_nxt_s = 1'b0;
        end else if (outstanding_r) begin
          if (iCore_result_valid) begin
            outstanding_nxt_s = 1'b0;
            state_nxt_s       = (remain_r == CNT_ZERO) ? S_LEN : S_TEXT;
          end else begin
            outstanding_nxt_s = 1'b1;
          end
        end else if (remain_r == CNT_ZERO) begin
          if (iCore_ready) begin
            blk_last_s  = 1'b1;
            state_nxt_s = S_LEN;
          end else begin
            blk_last_s = 1'b0;
          end
        end else begin
          data_ready_s = iCore_ready;
          if (iData_valid && iCore_ready) begin
            blk_valid_s       = 1'b1;
            blk_last_s        = (remain_r == CNT_ONE);
            remain_nxt_s      = remain_r - CNT_ONE;
            outstanding_nxt_s = 1'b1;
          end else begin
            blk_valid_s = 1'b0;
          end
        end
      end
      S_LEN: state_nxt_s = S_WAIT_TAG;
      S_WAIT_TAG: begin
        if (timeout_s) begin
          state_nxt_s = S_IDLE;
          init_nxt_s  = 1'b0;
          err_nxt_s   = 1'b1;
        end else if (iCore_tag_valid) begin
          state_nxt_s = S_IDLE;
          init_nxt_s  = 1'b0;
          done_nxt_s  = 1'b1;
        end else begin
          state_nxt_s = S_WAIT_TAG;
        end
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // State and job-context registers.
  always_ff @(posedge iClk) begin
    if (!iRstn) begin
      state_r        <= S_IDLE;
      aad_blks_r     <= CNT_ZERO;
      txt_blks_r     <= CNT_ZERO;
      remain_r       <= CNT_ZERO;
      outstanding_r  <= 1'b0;
      key_armed_r    <= 1'b0;
      init_r         <= 1'b0;
      encdec_r       <= 1'b0;
      done_r         <= 1'b0;
      err_r          <= 1'b0;
      core_ready_d_r <= 1'b0;
    end else begin
      state_r        <= state_nxt_s;
      aad_blks_r     <= aad_blks_nxt_s;
      txt_blks_r     <= txt_blks_nxt_s;
      remain_r       <= remain_nxt_s;
      outstanding_r  <= outstanding_nxt_s;
      key_armed_r    <= key_armed_nxt_s;
      init_r         <= init_nxt_s;
      encdec_r       <= encdec_nxt_s;
      done_r         <= done_nxt_s;
      err_r          <= err_nxt_s;
      core_ready_d_r <= iCore_ready;
    end
  end

  // Core watchdog: reloads on any core progress, cleared whenever not blocked on the core.
  always_ff @(posedge iClk) begin
    if (!iRstn) begin
      wait_cnt_r <= {WAIT_W{1'b0}};
    end else if (!wait_core_s || progress_s || timeout_s) begin
      wait_cnt_r <= {WAIT_W{1'b0}};
    end else begin
      wait_cnt_r <= wait_cnt_r + WAIT_ONE;
    end
  end

`ifdef GCM_SEQ_PERF_EN
  logic [31:0] perf_cnt_r, perf_r;

  // Accept-to-done cycle counter, saturating.
  always_ff @(posedge iClk) begin
    if (!iRstn) begin
      perf_cnt_r <= 32'd0;
      perf_r     <= 32'd0;
    end else begin
      if (state_r == S_IDLE) begin
        perf_cnt_r <= 32'd1;
      end else if (perf_cnt_r != 32'hFFFF_FFFF) begin
        perf_cnt_r <= perf_cnt_r + 32'd1;
      end else begin
        perf_cnt_r <= perf_cnt_r;
      end
      if (done_nxt_s) begin
        perf_r <= perf_cnt_r;
      end else begin
        perf_r <= perf_r;
      end
    end
  end

  assign oPerf_cycles = perf_r;
`endif

  assign oJob_ready        = (state_r == S_IDLE);
  assign oBusy             = (state_r != S_IDLE);
  assign oCore_init        = init_r;
  assign oCore_encdec      = encdec_r;
  assign oDone             = done_r;
  assign oErr_timeout      = err_r;
  assign oData_ready       = iRstn & data_ready_s;
  assign oCore_aad_valid   = iRstn & aad_valid_s;
  assign oCore_aad_last    = iRstn & aad_last_s;
  assign oCore_block_valid = iRstn & blk_valid_s;
  assign oCore_block_last  = iRstn & blk_last_s;
  assign oCore_block       = blk_valid_s ? iData : {128{1'b0}};
  assign oCore_aad         = aad_valid_s ? iData :
                             ((state_r == S_LEN) || (state_r == S_WAIT_TAG)) ? len_blk_s : {128{1'b0}};

endmodule

// File: tb/tb_gcm_job_sequencer.sv
// Directed bench for gcm_job_sequencer: a small reactive core model plus a stream scoreboard.
module tb_gcm_job_sequencer;
  localparam int TO = 4096;

  logic         iClk = 1'b0, iRstn = 1'b0;
  logic         iJob_valid = 1'b0, iJob_encdec = 1'b0;
  logic [15:0]  iJob_aad_blks = 16'd0, iJob_txt_blks = 16'd0;
  logic [127:0] iData = 128'd0;
  logic         iData_valid = 1'b0;
  logic         iCore_ready = 1'b1, iCore_result_valid = 1'b0, iCore_tag_valid = 1'b0;
  logic         oJob_ready, oData_ready, oCore_init, oCore_encdec;
  logic [127:0] oCore_aad, oCore_block;
  logic         oCore_aad_valid, oCore_aad_last, oCore_block_valid, oCore_block_last;
  logic         oBusy, oDone, oErr_timeout;
`ifdef GCM_SEQ_PERF_EN
  logic [31:0]  oPerf_cycles;
`endif

  gcm_job_sequencer #(.LEN_W(16), .TIMEOUT_CYC(TO)) dut (
    .iClk(iClk), .iRstn(iRstn), .iJob_valid(iJob_valid), .oJob_ready(oJob_ready),
    .iJob_aad_blks(iJob_aad_blks), .iJob_txt_blks(iJob_txt_blks), .iJob_encdec(iJob_encdec),
    .iData(iData), .iData_valid(iData_valid), .oData_ready(oData_ready),
    .oCore_init(oCore_init), .oCore_encdec(oCore_encdec), .iCore_ready(iCore_ready),
    .oCore_aad(oCore_aad), .oCore_aad_valid(oCore_aad_valid), .oCore_aad_last(oCore_aad_last),
    .oCore_block(oCore_block), .oCore_block_valid(oCore_block_valid),
    .oCore_block_last(oCore_block_last), .iCore_result_valid(iCore_result_valid),
    .iCore_tag_valid(iCore_tag_valid), .oBusy(oBusy), .oDone(oDone), .oErr_timeout(oErr_timeout)
`ifdef GCM_SEQ_PERF_EN
    , .oPerf_cycles(oPerf_cycles)
`endif
  );

  always #5 iClk = ~iClk;

  int tests = 0, fails = 0;
  int cyc = 0;
  always @(posedge iClk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Source words for the current job: AAD blocks first, then text blocks.
  logic [127:0] src [0:7];

  // ---------------- core model (stimulus only) ----------------
  bit hold_result = 0;
  bit init_seen = 0, res_out = 0, tag_pending = 0;
  int key_cnt = 0, res_cnt = 0, tag_cnt = 0;
  initial begin
    bit nr, nres, ntag;
    forever begin
      @(negedge iClk);
      nr = iCore_ready; nres = 1'b0; ntag = 1'b0;
      if (!oCore_init) begin
        nr = 1'b1; init_seen = 0; key_cnt = 0; res_out = 0; res_cnt = 0; tag_pending = 0; tag_cnt = 0;
      end else begin
        if (!init_seen) begin
          init_seen = 1; nr = 1'b0; key_cnt = 3;
        end else if (key_cnt > 0) begin
          key_cnt--;
          if (key_cnt == 0) nr = 1'b1;
        end
        if (oCore_block_valid) begin
          nr = 1'b0; res_out = 1; res_cnt = 2;
        end else if (res_out && !hold_result) begin
          if (res_cnt > 0) res_cnt--;
          else begin nres = 1'b1; nr = 1'b1; res_out = 0; end
        end
        if (tag_pending && !res_out) begin
          tag_cnt--;
          if (tag_cnt == 0) begin ntag = 1'b1; tag_pending = 0; end
        end
        if (oCore_block_last) begin tag_pending = 1; tag_cnt = 4; end
      end
      @(posedge iClk); #1;
      iCore_ready = nr; iCore_result_valid = nres; iCore_tag_valid = ntag;
    end
  end

  // ---------------- scoreboard / compare process ----------------
  int exp_a = 0, exp_t = 0, aad_i = 0, txt_i = 0;
  int aad_last_n = 0, blk_last_n = 0, last_beat = 0, done_n = 0;
  bit exp_enc = 0;
  logic [127:0] len_seen = 128'd0;
  always @(negedge iClk) begin
    if (iRstn) begin
      if (oDone) begin
        done_n++;
        check("done_aad_count", aad_i, exp_a);
        check("done_txt_count", txt_i, exp_t);
      end
      if (iJob_valid && oJob_ready) begin
        exp_a = iJob_aad_blks; exp_t = iJob_txt_blks; exp_enc = iJob_encdec;
        aad_i = 0; txt_i = 0; aad_last_n = 0; blk_last_n = 0; last_beat = 0;
      end
      if (oCore_aad_valid || oCore_block_valid)
        check("strobe_on_accepted_beat", iData_valid & oData_ready, 1'b1);
      if (oCore_aad_valid) begin
        check("aad_in_range", aad_i < exp_a, 1'b1);
        check("aad_data", oCore_aad, src[aad_i]);
        check("aad_last_flag", oCore_aad_last, aad_i == exp_a - 1);
        aad_i++;
      end else if (oCore_aad_last) begin
        check("aad_empty_pulse", exp_a, 0);
      end
      if (oCore_aad_last) aad_last_n++;
      if (oCore_block_valid) begin
        check("txt_in_range", txt_i < exp_t, 1'b1);
        check("txt_after_aad", aad_i, exp_a);
        check("txt_data", oCore_block, src[exp_a + txt_i]);
        check("blk_last_flag", oCore_block_last, txt_i == exp_t - 1);
        txt_i++;
        if (oCore_block_last) last_beat = exp_a + txt_i;
      end else if (oCore_block_last) begin
        check("blk_empty_pulse", exp_t, 0);
      end
      if (oCore_block_last) blk_last_n++;
      if (iCore_tag_valid) begin
        len_seen = oCore_aad;
        check("len_block", oCore_aad, {64'(exp_a) * 64'd128, 64'(exp_t) * 64'd128});
        check("encdec", oCore_encdec, exp_enc);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic start_job(input int a, input int t, input bit enc, input bit hold);
    bit ok = 0;
    iJob_aad_blks = 16'(a); iJob_txt_blks = 16'(t); iJob_encdec = enc; iJob_valid = 1'b1;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge iClk); ok = oJob_ready;
      @(posedge iClk); #1;
    end
    if (!hold) iJob_valid = 1'b0;
    check("job_accept", ok, 1'b1);
  endtask

  task automatic send_beats(input int n, input bit toggle, output int issue_cyc);
    int i = 0, g = 0;
    bit fire;
    issue_cyc = 0;
    while (i < n && g < 2000) begin
      iData = src[i];
      iData_valid = toggle ? (g % 2 == 0) : 1'b1;
      @(negedge iClk); fire = iData_valid & oData_ready;
      if (fire) issue_cyc = cyc;
      @(posedge iClk); #1;
      if (fire) i++;
      g++;
    end
    iData_valid = 1'b0;
    check("beats_consumed", i, n);
  endtask

  task automatic wait_done();
    bit got = 0;
    for (int k = 0; k < 500 && !got; k++) begin
      @(negedge iClk); got = oDone;
      @(posedge iClk); #1;
    end
    check("done_seen", got, 1'b1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ic, lat, d0;
    bit got, early;
    repeat (3) @(posedge iClk);
    #1;
    // Reset state.
    @(negedge iClk);
    check("rst_job_ready", oJob_ready, 1'b1);
    check("rst_outputs", {oBusy, oDone, oErr_timeout, oCore_init, oCore_encdec, oData_ready,
                          oCore_aad_valid, oCore_aad_last, oCore_block_valid, oCore_block_last}, 10'd0);
    check("rst_aad_bus", oCore_aad, 128'd0);
    @(posedge iClk); #1;
    iRstn = 1'b1;
    repeat (2) @(posedge iClk);
    #1;

    // Job 1: one AAD block, two text blocks, encrypt (TC4-style data).
    src[0] = 128'hfeedfacedeadbeeffeedfacedeadbeef;
    src[1] = 128'hd9313225f88406e5a55909c5aff5269a;
    src[2] = 128'h86a7a9531534f7da2e4c303d8a318a72;
    d0 = done_n;
    start_job(1, 2, 1'b1, 1'b0);
    send_beats(3, 1'b0, ic);
    wait_done();
    check("j1_done_once", done_n - d0, 1);
    check("j1_aad_last_once", aad_last_n, 1);
    check("j1_blk_last_once", blk_last_n, 1);
    check("j1_blk_last_beat", last_beat, 3);
    check("j1_len_literal", len_seen, 128'h0000000000000080_0000000000000100);
    check("j1_idle_after", {oBusy, oJob_ready}, 2'b01);

    // Job 2: empty job.
    d0 = done_n;
    start_job(0, 0, 1'b0, 1'b0);
    wait_done();
    check("j2_done_once", done_n - d0, 1);
    check("j2_aad_last_pulse", aad_last_n, 1);
    check("j2_blk_last_pulse", blk_last_n, 1);
    check("j2_len_zero", len_seen, 128'd0);

    // Job 3: 2 AAD + 3 text, source toggling, decrypt.
    for (int k = 0; k < 5; k++) src[k] = {32'hA5A5_0000 + 32'(k), 32'h1111_1111 * 32'(k + 1), 64'(k * 7 + 3)};
    d0 = done_n;
    start_job(2, 3, 1'b0, 1'b0);
    send_beats(5, 1'b1, ic);
    wait_done();
    check("j3_done_once", done_n - d0, 1);
    check("j3_blk_last_beat", last_beat, 5);
    check("j3_len_literal", len_seen, 128'h0000000000000100_0000000000000180);

    // Job 4: core result withheld -> timeout.
    src[0] = 128'h0123456789abcdef0123456789abcdef;
    hold_result = 1;
    d0 = done_n;
    start_job(0, 1, 1'b1, 1'b0);
    send_beats(1, 1'b0, ic);
    got = 0; early = 0; lat = 0;
    for (int k = 0; k < 5000 && !got; k++) begin
      @(negedge iClk);
      got = oErr_timeout;
      if (got) lat = cyc - ic;
      @(posedge iClk); #1;
    end
    check("to_flag", got, 1'b1);
    check("to_latency_window", (lat >= TO - 1) && (lat <= TO + 3), 1'b1);
    @(negedge iClk);
    check("to_state", {oBusy, oJob_ready, oCore_init, oDone}, 4'b0100);
    check("to_no_done", done_n - d0, 0);
    @(posedge iClk); #1;
    hold_result = 0;
    src[0] = 128'h1; src[1] = 128'h2;
    start_job(1, 1, 1'b0, 1'b0);
    @(negedge iClk);
    check("to_err_cleared_on_accept", oErr_timeout, 1'b0);
    @(posedge iClk); #1;
    send_beats(2, 1'b0, ic);
    wait_done();

    // Job 5: reset asserted while a text block is outstanding.
    src[0] = 128'hAAAA; src[1] = 128'hBBBB; src[2] = 128'hCCCC;
    hold_result = 1;
    start_job(1, 2, 1'b1, 1'b0);
    send_beats(2, 1'b0, ic);
    repeat (3) @(posedge iClk);
    #1;
    check("pre_reset_busy", oBusy, 1'b1);
    iRstn = 1'b0;
    @(posedge iClk); #1;
    @(negedge iClk);
    check("post_reset_strobes", {oData_ready, oCore_aad_valid, oCore_aad_last, oCore_block_valid,
                                 oCore_block_last, oCore_init, oDone}, 7'd0);
    check("post_reset_busy_ready", {oBusy, oJob_ready}, 2'b01);
    @(posedge iClk); #1;
    iRstn = 1'b1; hold_result = 0;
    repeat (2) @(posedge iClk);
    #1;

    // Jobs 6/7: second descriptor held valid during the first.
    src[0] = 128'h600D; src[1] = 128'hF00D;
    d0 = done_n;
    start_job(1, 1, 1'b1, 1'b1);
    iJob_aad_blks = 16'd0; iJob_txt_blks = 16'd1; iJob_encdec = 1'b0;
    send_beats(2, 1'b0, ic);
    got = 0; early = 0;
    for (int k = 0; k < 500 && !got; k++) begin
      @(negedge iClk);
      got = oJob_ready;
      if (got) check("b2b_accept_with_done", oDone, 1'b1);
      @(posedge iClk); #1;
    end
    iJob_valid = 1'b0;
    check("b2b_second_accepted", got, 1'b1);
    check("b2b_first_done", done_n - d0, 1);
    src[0] = 128'hBEEF;
    send_beats(1, 1'b0, ic);
    wait_done();
    check("b2b_second_done", done_n - d0, 2);
    check("b2b_len_literal", len_seen, 128'h0000000000000000_0000000000000080);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
